count_display_mon: RTL and testbench
====================================

COUNT_DISPLAY_MON -- requirements
Module: count_display_mon

Interface
REQ-001 Parameter: REFRESH_DIV, 16'd50000, clocks each display digit is held active; legal range 2..65535.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: count  input  4  value from the upstream up/down counter, 0..15.
REQ-005 Port: seg  output  7  active-low segments, bit order {g,f,e,d,c,b,a}, registered.
REQ-006 Port: an  output  2  active-low digit enables; an[0] = ones digit, an[1] = tens digit; registered.
REQ-007 Port: ovf_pulse  output  1  one-clock pulse on a 15->0 transition of count.
REQ-008 Port: unf_pulse  output  1  one-clock pulse on a 0->15 transition of count.
REQ-009 Port: wrap_cnt  output  8  saturating total of ovf and unf events.

Function
REQ-010 The block SHALL register count into cnt_q on every clock edge; cnt_q is the only count source for all other logic.
REQ-011 The block SHALL hold a prev_valid flag that is cleared by reset and set at the first edge after reset deasserts.
REQ-012 ovf_pulse SHALL be high for exactly one cycle, registered at the edge where prev_valid=1, cnt_q=15 and count=0.
REQ-013 unf_pulse SHALL be high for exactly one cycle, registered at the edge where prev_valid=1, cnt_q=0 and count=15.
REQ-014 Any other change of count (step +/-1 not crossing 15/0, jumps such as 15->3, holds) SHALL produce no pulse.
REQ-015 The wrap check SHALL use values only; no direction input is consulted.
REQ-016 wrap_cnt SHALL increment by 1 at the same edge that asserts ovf_pulse or unf_pulse.
REQ-017 wrap_cnt SHALL saturate at 255 and SHALL never wrap to 0.
REQ-018 Decimal split of cnt_q: tens = 1 if cnt_q >= 10, else 0; ones = cnt_q - 10*tens.
REQ-019 A 16-bit refresh counter SHALL count 0..REFRESH_DIV-1 and return to 0.
REQ-020 Digit select sel SHALL toggle at each edge where the refresh counter is at REFRESH_DIV-1.
REQ-021 With sel=0, the next edge SHALL register an=2'b10 and seg=pattern(ones).
REQ-022 With sel=1 and tens=1, the next edge SHALL register an=2'b01 and seg=pattern(1).
REQ-023 With sel=1 and tens=0 (leading-zero blanking), the next edge SHALL register an=2'b11 and seg=7'h7F.
REQ-024 Segment patterns (active-low, gfedcba):
  0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001,
  5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-025 seg/an SHALL lag count by two edges: one for cnt_q capture, one for the output register.

Reset
REQ-026 While rst=1 at an edge, the block SHALL set: cnt_q=0, prev_valid=0, refresh counter=0, sel=0, ovf_pulse=0, unf_pulse=0, wrap_cnt=0, an=2'b11, seg=7'h7F.
REQ-027 Reset asserted mid-refresh or mid-pulse SHALL take priority over all other updates; a pending pulse is dropped.
REQ-028 The first sample after reset SHALL NOT generate a pulse, even if count is 15 or 0 around the reset boundary.

Verification
REQ-029 Hold count=7, REFRESH_DIV=4 -> an alternates 2'b10 (seg=1111000) and 2'b11 (seg=7'h7F) every 4 clocks; no pulses.
REQ-030 Hold count=13, REFRESH_DIV=4 -> an alternates 2'b10 (seg=0110000) and 2'b01 (seg=1111001).
REQ-031 Count up 14,15,0,1 on consecutive clocks -> exactly one ovf_pulse, at the edge capturing 0; wrap_cnt 0->1.
REQ-032 Count down 1,0,15,14 -> exactly one unf_pulse; count jumps 15->3 and 0->9 -> no pulse, wrap_cnt unchanged.
REQ-033 Drive 300 alternating 15/0 transitions -> wrap_cnt reaches 255 and stays at 255.
REQ-034 Assert rst for one cycle with count=15, release with count=0 -> no ovf_pulse, all outputs at reset values for that cycle, wrap_cnt=0.

Source files
------------

// File: rtl/count_display_mon.sv
// Two-digit multiplexed 7-segment display of a 0..15 counter value, plus
// detection and saturating counting of 15->0 / 0->15 wrap events.
module count_display_mon #(
  parameter logic [15:0] REFRESH_DIV = 16'd50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] count,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       ovf_pulse,
  output logic       unf_pulse,
  output logic [7:0] wrap_cnt
);

  logic [3:0]  cnt_q;
  logic        prev_valid_q;
  logic [15:0] refresh_q, refresh_d;
  logic        sel_q, sel_d;
  logic        ovf_q, ovf_d;
  logic        unf_q, unf_d;
  logic [7:0]  wrap_q, wrap_d;
  logic [6:0]  seg_q, seg_d;
  logic [1:0]  an_q, an_d;
  logic        tens;
  logic [3:0]  ones;
  logic        refresh_last;

  function automatic logic [6:0] pattern(input logic [3:0] digit);
    logic [6:0] p;
    case (digit)
      4'd0:    p = 7'b1000000;
      4'd1:    p = 7'b1111001;
      4'd2:    p = 7'b0100100;
      4'd3:    p = 7'b0110000;
      4'd4:    p = 7'b0011001;
      4'd5:    p = 7'b0010010;
      4'd6:    p = 7'b0000010;
      4'd7:    p = 7'b1111000;
      4'd8:    p = 7'b0000000;
      4'd9:    p = 7'b0010000;
      default: p = 7'h7F;
    endcase
    return p;
  endfunction

  always_comb begin
    // Wrap detection is purely value-based: previous sample vs. incoming value.
    ovf_d = prev_valid_q && (cnt_q == 4'd15) && (count == 4'd0);
    unf_d = prev_valid_q && (cnt_q == 4'd0) && (count == 4'd15);

    wrap_d = wrap_q;
    if ((ovf_d || unf_d) && (wrap_q != 8'hFF)) begin
      wrap_d = wrap_q + 8'd1;
    end

    refresh_last = (refresh_q == REFRESH_DIV - 16'd1);
    refresh_d    = refresh_last ? 16'd0 : refresh_q + 16'd1;
    sel_d        = sel_q ^ refresh_last;

    tens = (cnt_q >= 4'd10);
    ones = tens ? cnt_q - 4'd10 : cnt_q;

    an_d  = 2'b11;
    seg_d = 7'h7F;
    if (!sel_q) begin
      an_d  = 2'b10;
      seg_d = pattern(ones);
    end else if (tens) begin
      an_d  = 2'b01;
      seg_d = pattern(4'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= 4'd0;
      prev_valid_q <= 1'b0;
      refresh_q    <= 16'd0;
      sel_q        <= 1'b0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
      wrap_q       <= 8'd0;
      an_q         <= 2'b11;
      seg_q        <= 7'h7F;
    end else begin
      cnt_q        <= count;
      prev_valid_q <= 1'b1;
      refresh_q    <= refresh_d;
      sel_q        <= sel_d;
      ovf_q        <= ovf_d;
      unf_q        <= unf_d;
      wrap_q       <= wrap_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
    end
  end

  assign seg       = seg_q;
  assign an        = an_q;
  assign ovf_pulse = ovf_q;
  assign unf_pulse = unf_q;
  assign wrap_cnt  = wrap_q;

endmodule

// File: tb/tb_count_display_mon.sv
// Randomized scoreboard bench for count_display_mon against an edge-indexed
// arithmetic model of the display refresh and wrap counting.
module tb_count_display_mon;

  localparam int Div = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] count = 4'd0;
  logic [6:0] seg;
  logic [1:0] an;
  logic       ovf_pulse, unf_pulse;
  logic [7:0] wrap_cnt;

  count_display_mon #(.REFRESH_DIV(16'(Div))) dut (
    .clk      (clk),
    .rst      (rst),
    .count    (count),
    .seg      (seg),
    .an       (an),
    .ovf_pulse(ovf_pulse),
    .unf_pulse(unf_pulse),
    .wrap_cnt (wrap_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] seg;
    logic [1:0] an;
    logic       ovf;
    logic       unf;
    logic [7:0] wrap;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [6:0] pat [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                           7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  // Model state: k = non-reset edges since last reset, last = count at edge k.
  int k     = 0;
  int last  = 0;
  int wraps = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  task automatic step(input logic r, input int c);
    exp_t e;
    int   sel;
    @(negedge clk);
    rst   = r;
    count = 4'(c);
    if (r) begin
      k = 0; last = 0; wraps = 0;
      e = '{seg: 7'h7F, an: 2'b11, ovf: 1'b0, unf: 1'b0, wrap: 8'd0};
    end else begin
      k++;
      sel = ((k - 1) / Div) % 2;
      if (sel == 0) begin
        e.an  = 2'b10;
        e.seg = pat[last % 10];
      end else if (last >= 10) begin
        e.an  = 2'b01;
        e.seg = pat[1];
      end else begin
        e.an  = 2'b11;
        e.seg = 7'h7F;
      end
      e.ovf = (k >= 2) && (last == 15) && (c == 0);
      e.unf = (k >= 2) && (last == 0) && (c == 15);
      if (e.ovf || e.unf) wraps = (wraps < 255) ? wraps + 1 : 255;
      e.wrap = 8'(wraps);
      last = c;
    end
    sb.push_back(e);
  endtask

  // Monitor: one registered output set per clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("seg", int'(seg), int'(e.seg));
        check("an", int'(an), int'(e.an));
        check("ovf_pulse", int'(ovf_pulse), int'(e.ovf));
        check("unf_pulse", int'(unf_pulse), int'(e.unf));
        check("wrap_cnt", int'(wrap_cnt), int'(e.wrap));
      end
    end
  end

  initial begin
    int c;
    int wait_cycles;
    step(1'b1, 15);
    step(1'b1, 0);
    for (int i = 0; i < 12; i++) step(1'b0, 7);
    for (int i = 0; i < 12; i++) step(1'b0, 13);
    step(1'b0, 14); step(1'b0, 15); step(1'b0, 0); step(1'b0, 1);
    step(1'b0, 1); step(1'b0, 0); step(1'b0, 15); step(1'b0, 14);
    step(1'b0, 15); step(1'b0, 3); step(1'b0, 0); step(1'b0, 9);
    step(1'b0, 9);
    for (int i = 0; i < 300; i++) step(1'b0, (i % 2 == 0) ? 15 : 0);
    for (int i = 0; i < 4; i++) step(1'b0, 0);
    // Reset boundary with wrap-like values on both sides.
    step(1'b0, 15);
    step(1'b1, 15);
    step(1'b0, 0);
    step(1'b0, 15);
    step(1'b0, 0);
    step(1'b0, 0);
    step(1'b1, 0);
    step(1'b0, 15);
    step(1'b0, 15);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        step(1'b1, int'($urandom_range(0, 15)));
      end else begin
        if ($urandom_range(0, 2) == 0 && (last == 15 || last == 0)) c = 15 - last;
        else if ($urandom_range(0, 3) == 0) c = last;
        else c = int'($urandom_range(0, 15));
        step(1'b0, c);
      end
    end
    wait_cycles = 0;
    while (sb.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    #2;
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
